// File: rtl/swipt_backchannel_rx.sv
// SWIPT back-channel receiver: hysteresis comparator, glitch filter, UART-style frame decoder, FWFT output FIFO.
// Optional even-parity bit between data bit 7 and the stop bit when SWIPT_BACKCHANNEL_PARITY_EN is defined.
module swipt_backchannel_rx #(
    parameter int unsigned ADC_W       = 12,
    parameter int unsigned BIT_CYCLES  = 1000,
    parameter int unsigned FILT_CYCLES = 4,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             i_enable,
    input  logic [ADC_W-1:0] i_adc,
    input  logic [ADC_W-1:0] i_thresh_hi,
    input  logic [ADC_W-1:0] i_thresh_lo,
    output logic [7:0]       o_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_busy,
    output logic             o_level,
    output logic [15:0]      o_frame_err_cnt,
`ifdef SWIPT_BACKCHANNEL_PARITY_EN
    output logic [15:0]      o_parity_err_cnt,
`endif
    output logic             o_overflow
);

    localparam int unsigned CNT_W  = $clog2(BIT_CYCLES);
    localparam int unsigned FILT_W = $clog2(FILT_CYCLES + 1);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W  = PTR_W + 1;

    localparam logic [CNT_W-1:0]  HALF_CNT = CNT_W'(BIT_CYCLES / 2 - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(BIT_CYCLES - 1);
    localparam logic [FILT_W-1:0] FILT_END = FILT_W'(FILT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
`ifdef SWIPT_BACKCHANNEL_PARITY_EN
        , PARITY
`endif
    } state_t;

    state_t              state;
    logic                raw;
    logic [FILT_W-1:0]   run;
    logic [CNT_W-1:0]    cnt;
    logic [2:0]          idx;
    logic [7:0]          shreg;
    logic                bit_end;
    logic                push_c;
    logic                pop_c;
    logic                full;
    logic                wr_en;
    logic [7:0]          mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [OCC_W-1:0]    occ;
`ifdef SWIPT_BACKCHANNEL_PARITY_EN
    logic                par_bad;
`endif

    // Hysteresis comparator; the high test has priority for misordered thresholds.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            raw <= 1'b1;
        end else if (i_adc >= i_thresh_hi) begin
            raw <= 1'b1;
        end else if (i_adc <= i_thresh_lo) begin
            raw <= 1'b0;
        end
    end

    // Glitch filter: level follows raw only after FILT_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            o_level <= 1'b1;
            run     <= '0;
        end else if (!i_enable || (raw == o_level)) begin
            run <= '0;
        end else if (run == FILT_END) begin
            o_level <= raw;
            run     <= '0;
        end else begin
            run <= run + FILT_W'(1);
        end
    end

    assign bit_end = (cnt == FULL_CNT);

`ifdef SWIPT_BACKCHANNEL_PARITY_EN
    assign push_c = i_enable && (state == STOP) && bit_end && o_level && !par_bad;
`else
    assign push_c = i_enable && (state == STOP) && bit_end && o_level;
`endif

    // Frame decoder; samples near mid-bit, counting from the filtered start edge.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state           <= IDLE;
            cnt             <= '0;
            idx             <= '0;
            shreg           <= '0;
            o_frame_err_cnt <= '0;
`ifdef SWIPT_BACKCHANNEL_PARITY_EN
            par_bad          <= 1'b0;
            o_parity_err_cnt <= '0;
`endif
        end else if (!i_enable) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!o_level) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (cnt == HALF_CNT) begin
                        cnt   <= '0;
                        idx   <= '0;
                        state <= o_level ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt        <= '0;
                        shreg[idx] <= o_level;
                        idx        <= idx + 3'd1;
                        if (idx == 3'd7) begin
`ifdef SWIPT_BACKCHANNEL_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`ifdef SWIPT_BACKCHANNEL_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        cnt     <= '0;
                        state   <= STOP;
                        par_bad <= (o_level != ^shreg);
                        if ((o_level != ^shreg) && (o_parity_err_cnt != 16'hFFFF)) begin
                            o_parity_err_cnt <= o_parity_err_cnt + 16'd1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (o_level) begin
                            state <= IDLE;
                        end else begin
                            state <= WAIT_IDLE;
                            if (o_frame_err_cnt != 16'hFFFF) begin
                                o_frame_err_cnt <= o_frame_err_cnt + 16'd1;
                            end
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WAIT_IDLE: begin
                    if (o_level) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_busy  = (state != IDLE);
    assign o_valid = (occ != '0);
    assign o_data  = mem[rd_ptr];
    assign full    = (occ == OCC_W'(FIFO_DEPTH));
    assign pop_c   = o_valid && i_ready;
    assign wr_en   = push_c && (!full || pop_c);

    // First-word-fall-through FIFO; a push into a full FIFO without a pop is dropped.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= shreg;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push_c && full && !pop_c) begin
                o_overflow <= 1'b1;
            end
            case ({wr_en, pop_c})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: tb/tb_swipt_backchannel_rx.sv
// Self-checking bench for swipt_backchannel_rx: directed frame table, corner sequences and random frames
// checked against a byte-queue / error-count model. Parity checks build when SWIPT_BACKCHANNEL_PARITY_EN is set.
module tb_swipt_backchannel_rx;

    localparam int BC = 16;

    logic        clk;
    logic        nrst;
    logic        i_enable;
    logic [11:0] i_adc;
    logic [11:0] i_thresh_hi;
    logic [11:0] i_thresh_lo;
    logic [7:0]  o_data;
    logic        o_valid;
    logic        i_ready;
    logic        o_busy;
    logic        o_level;
    logic [15:0] o_frame_err_cnt;
    logic        o_overflow;
`ifdef SWIPT_BACKCHANNEL_PARITY_EN
    logic [15:0] o_parity_err_cnt;
`endif

    swipt_backchannel_rx #(
        .ADC_W(12), .BIT_CYCLES(BC), .FILT_CYCLES(2), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .nrst(nrst), .i_enable(i_enable), .i_adc(i_adc),
        .i_thresh_hi(i_thresh_hi), .i_thresh_lo(i_thresh_lo),
        .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
        .o_busy(o_busy), .o_level(o_level), .o_frame_err_cnt(o_frame_err_cnt),
`ifdef SWIPT_BACKCHANNEL_PARITY_EN
        .o_parity_err_cnt(o_parity_err_cnt),
`endif
        .o_overflow(o_overflow)
    );

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         hold;
        logic       push;
        int         exp_err;
    } vec_t;

    int         checks;
    int         errors;
    int         err_model;
    int         perr_model;
    int         rd_idx;
    int         got_wr;
    int         valid_cycles;
    logic [7:0] got_mem [256];
    logic [7:0] exp_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every accepted pop and every cycle with valid high.
    always @(negedge clk) begin
        if (nrst) begin
            if (o_valid) valid_cycles <= valid_cycles + 1;
            if (o_valid && i_ready) begin
                got_mem[8'(got_wr)] <= o_data;
                got_wr              <= got_wr + 1;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_line(input logic hi);
        i_adc = hi ? 12'd3000 : 12'd500;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
        set_line(1'b0);
        cycles(BC);
        for (int i = 0; i < 8; i++) begin
            set_line(b[i]);
            cycles(BC);
        end
`ifdef SWIPT_BACKCHANNEL_PARITY_EN
        set_line(par);
        cycles(BC);
`else
        if (par === 1'bx) $display("parity bit unknown");
`endif
        set_line(stop);
        cycles(BC);
    endtask

    task automatic drain_check();
        while (rd_idx < got_wr) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop: got 0x%0h expected no byte", got_mem[8'(rd_idx)]);
            end else begin
                check("pop_data", 32'(got_mem[8'(rd_idx)]), 32'(exp_q.pop_front()));
            end
            rd_idx++;
        end
    endtask

    task automatic frame_done(input int hold, input logic stop);
        if (!stop) begin
            set_line(1'b0);
            cycles(hold);
            check("wait_idle_busy", 32'(o_busy), 1);
        end
        set_line(1'b1);
        cycles(8);
        check("busy_clear", 32'(o_busy), 0);
        check("frame_err_cnt", 32'(o_frame_err_cnt), err_model);
`ifdef SWIPT_BACKCHANNEL_PARITY_EN
        check("parity_err_cnt", 32'(o_parity_err_cnt), perr_model);
`endif
        drain_check();
        check("all_pushed", exp_q.size(), 0);
    endtask

    initial begin
        vec_t tbl [6];
        int   vc0;

        tbl[0] = '{8'h5A, 1'b1, 0,  1'b1, 0};
        tbl[1] = '{8'h3C, 1'b0, 40, 1'b0, 1};
        tbl[2] = '{8'hC3, 1'b1, 0,  1'b1, 1};
        tbl[3] = '{8'h00, 1'b1, 0,  1'b1, 1};
        tbl[4] = '{8'hFF, 1'b1, 0,  1'b1, 1};
        tbl[5] = '{8'h80, 1'b0, 5,  1'b0, 2};

        checks = 0; errors = 0; err_model = 0; perr_model = 0;
        rd_idx = 0; got_wr = 0; valid_cycles = 0;
        nrst = 1'b0; i_enable = 1'b1; i_ready = 1'b1;
        i_thresh_hi = 12'd2000; i_thresh_lo = 12'd1500;
        set_line(1'b1);
        cycles(3);
        check("rst_level", 32'(o_level), 1);
        check("rst_busy", 32'(o_busy), 0);
        check("rst_valid", 32'(o_valid), 0);
        check("rst_data", 32'(o_data), 0);
        check("rst_err", 32'(o_frame_err_cnt), 0);
        check("rst_ovf", 32'(o_overflow), 0);
        nrst = 1'b1;
        cycles(5);

        // Directed frame table
        for (int v = 0; v < 6; v++) begin
            vc0 = valid_cycles;
            if (tbl[v].push) exp_q.push_back(tbl[v].data);
            err_model = tbl[v].exp_err;
            send_frame(tbl[v].data, ^tbl[v].data, tbl[v].stop);
            frame_done(tbl[v].hold, tbl[v].stop);
            check("valid_cycles", valid_cycles - vc0, 32'(tbl[v].push));
        end

        // One-cycle glitch must not move the filtered level
        begin
            logic lvl_ok;
            logic idle_ok;
            lvl_ok = 1'b1; idle_ok = 1'b1;
            set_line(1'b0);
            cycles(1);
            set_line(1'b1);
            for (int i = 0; i < 8; i++) begin
                cycles(1);
                if (o_level !== 1'b1) lvl_ok = 1'b0;
                if (o_busy !== 1'b0) idle_ok = 1'b0;
            end
            check("glitch_level", 32'(lvl_ok), 1);
            check("glitch_idle", 32'(idle_ok), 1);
        end

        // Four-cycle low pulse: false start, no error, no byte
        vc0 = valid_cycles;
        set_line(1'b0);
        cycles(4);
        set_line(1'b1);
        cycles(3);
        check("false_start_busy", 32'(o_busy), 1);
        cycles(20);
        check("false_start_idle", 32'(o_busy), 0);
        check("false_start_err", 32'(o_frame_err_cnt), err_model);
        check("false_start_nopush", valid_cycles - vc0, 0);

        // Hysteresis: mid-band sample after a low keeps the level low
        set_line(1'b0);
        cycles(6);
        i_adc = 12'd1800;
        cycles(10);
        check("hysteresis_level", 32'(o_level), 0);
        set_line(1'b1);
        i_enable = 1'b0;
        cycles(2);
        i_enable = 1'b1;
        cycles(24);
        check("hyst_cleanup_idle", 32'(o_busy), 0);
        check("hyst_cleanup_err", 32'(o_frame_err_cnt), err_model);
        check("hyst_cleanup_nopush", valid_cycles - vc0, 0);

        // Overflow: five bytes into a four-entry FIFO with the consumer stalled
        i_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (k <= 4) exp_q.push_back(8'(k));
            send_frame(8'(k), ^(8'(k)), 1'b1);
            set_line(1'b1);
            cycles(4);
        end
        check("ovf_flag", 32'(o_overflow), 1);
        check("ovf_valid", 32'(o_valid), 1);
        check("ovf_head", 32'(o_data), 32'h01);
        i_ready = 1'b1;
        cycles(8);
        drain_check();
        check("ovf_all_drained", exp_q.size(), 0);
        check("ovf_empty", 32'(o_valid), 0);

        // Enable dropped mid-DATA of 0xFF discards the frame silently
        vc0 = valid_cycles;
        set_line(1'b0);
        cycles(BC);
        set_line(1'b1);
        cycles(4 * BC);
        check("en_mid_busy", 32'(o_busy), 1);
        i_enable = 1'b0;
        cycles(1);
        check("en_low_idle", 32'(o_busy), 0);
        cycles(6 * BC);
        i_enable = 1'b1;
        cycles(8);
        check("en_drop_err", 32'(o_frame_err_cnt), err_model);
        check("en_drop_nopush", valid_cycles - vc0, 0);
        exp_q.push_back(8'h00);
        send_frame(8'h00, 1'b0, 1'b1);
        frame_done(0, 1'b1);

`ifdef SWIPT_BACKCHANNEL_PARITY_EN
        // Bad parity is counted and not pushed; good parity pushes
        perr_model = 1;
        send_frame(8'h07, 1'b0, 1'b1);
        frame_done(0, 1'b1);
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b1);
        frame_done(0, 1'b1);
`endif

        // Random frames against the byte-queue / error-count model
        for (int n = 0; n < 16; n++) begin
            logic [7:0] b;
            logic       stop_ok;
            logic       par_ok;
            b       = 8'($urandom);
            stop_ok = ($urandom_range(0, 3) != 0);
`ifdef SWIPT_BACKCHANNEL_PARITY_EN
            par_ok  = ($urandom_range(0, 3) != 0);
`else
            par_ok  = 1'b1;
`endif
            if (stop_ok && par_ok) exp_q.push_back(b);
            if (!stop_ok) err_model++;
            if (!par_ok) perr_model++;
            send_frame(b, par_ok ? ^b : ~^b, stop_ok);
            frame_done(int'($urandom_range(1, 30)), stop_ok);
        end

        // Asynchronous reset mid-frame with a byte queued, overflow set and errors counted
        i_ready = 1'b0;
        send_frame(8'h96, ^(8'h96), 1'b1);
        set_line(1'b1);
        cycles(4);
        check("pre_rst_valid", 32'(o_valid), 1);
        check("pre_rst_data", 32'(o_data), 32'h96);
        set_line(1'b0);
        cycles(BC + 5);
        check("pre_rst_busy", 32'(o_busy), 1);
        nrst = 1'b0;
        #1;
        check("arst_level", 32'(o_level), 1);
        check("arst_busy", 32'(o_busy), 0);
        check("arst_valid", 32'(o_valid), 0);
        check("arst_data", 32'(o_data), 0);
        check("arst_err", 32'(o_frame_err_cnt), 0);
        check("arst_ovf", 32'(o_overflow), 0);
`ifdef SWIPT_BACKCHANNEL_PARITY_EN
        check("arst_perr", 32'(o_parity_err_cnt), 0);
`endif
        set_line(1'b1);
        cycles(3);
        nrst = 1'b1;
        cycles(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
